// File: rtl/branch_target_buffer_pkg.sv
// Shared definitions for the branch target buffer.
// Holds the table geometry, the direction-counter encodings, the entry
// layout and small helpers that split a PC into table index and tag.
package branch_target_buffer_pkg;

  localparam int BTB_INDEX_BITS = 4;
  localparam int BTB_TAG_BITS   = 15 - BTB_INDEX_BITS;
  localparam int BTB_ENTRIES    = 1 << BTB_INDEX_BITS;

  // 2-bit direction counter; bit 1 is the taken prediction.
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } btb_ctr_e;

  typedef struct packed {
    logic                    valid;
    logic [BTB_TAG_BITS-1:0] tag;
    logic [15:0]             target;
    logic [1:0]              ctr;
  } btb_entry_t;

  // Bit 0 of the PC is ignored, so PCs differing only there share an entry.
  function automatic logic [BTB_INDEX_BITS-1:0] pc_index(input logic [15:0] pc);
    return pc[BTB_INDEX_BITS:1];
  endfunction

  function automatic logic [BTB_TAG_BITS-1:0] pc_tag(input logic [15:0] pc);
    return pc[15:BTB_INDEX_BITS+1];
  endfunction

endpackage

// File: rtl/branch_target_buffer_if.sv
// Bundle of the fetch-side lookup, execute-side training and statistics
// signals of the branch target buffer.
//   slave  : the buffer itself (takes lookup/update/flush, drives prediction
//            and statistics)
//   master : the pipeline side driving lookups and training
interface branch_target_buffer_if;
  logic [15:0] i_pc;
  logic        o_valid;
  logic [15:0] o_BT;
  logic        i_upd_en;
  logic [15:0] i_upd_pc;
  logic        i_upd_taken;
  logic [15:0] i_upd_target;
  logic        i_flush;
  logic [15:0] o_hit_count;
  logic [15:0] o_alloc_count;

  modport slave (
    input  i_pc, i_upd_en, i_upd_pc, i_upd_taken, i_upd_target, i_flush,
    output o_valid, o_BT, o_hit_count, o_alloc_count
  );

  modport master (
    output i_pc, i_upd_en, i_upd_pc, i_upd_taken, i_upd_target, i_flush,
    input  o_valid, o_BT, o_hit_count, o_alloc_count
  );
endinterface

// File: rtl/btb_sat_counter.sv
// Next-state logic of a 2-bit saturating direction counter.
//   ctr      : current counter value
//   inc      : 1 = step towards strongly taken, 0 = towards strongly not-taken
//   ctr_next : stepped value, held at 2'b11 / 2'b00 at the ends
module btb_sat_counter
  import branch_target_buffer_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       inc,
  output logic [1:0] ctr_next
);

  always_comb begin
    ctr_next = ctr;
    if (inc) begin
      if (ctr != ST) ctr_next = ctr + 2'd1;
    end else begin
      if (ctr != SNT) ctr_next = ctr - 2'd1;
    end
  end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer.
// Fetch looks up i_pc combinationally (o_valid / o_BT in the same cycle);
// execute trains the table with resolved branches, written at posedge.
//   clk, reset : clock and synchronous active-high reset
//   bus        : lookup, update, flush and statistics signals (slave side)
module branch_target_buffer
  import branch_target_buffer_pkg::*;
#(
  parameter logic [1:0] CTR_ALLOC = 2'b10
) (
  input  logic                  clk,
  input  logic                  reset,
  branch_target_buffer_if.slave bus
);

  // Flops rather than RAM: the lookup read is asynchronous.
  btb_entry_t entry_reg  [BTB_ENTRIES];
  btb_entry_t entry_next [BTB_ENTRIES];

  logic [15:0] hit_count_reg;
  logic [15:0] alloc_count_reg;

  logic [BTB_INDEX_BITS-1:0] l_idx, u_idx;
  logic [BTB_TAG_BITS-1:0]   l_tag, u_tag;
  btb_entry_t                l_entry, u_entry;
  logic                      predict_taken;
  logic                      u_hit;
  logic                      upd_fire;
  logic                      alloc_fire;
  logic [1:0]                u_ctr_next;

  // Lookup reads the registered table, so a same-cycle update is not seen.
  assign l_idx         = pc_index(bus.i_pc);
  assign l_tag         = pc_tag(bus.i_pc);
  assign l_entry       = entry_reg[l_idx];
  assign predict_taken = l_entry.valid && (l_entry.tag == l_tag) && l_entry.ctr[1];

  assign bus.o_valid       = predict_taken;
  assign bus.o_BT          = predict_taken ? l_entry.target : 16'h0000;
  assign bus.o_hit_count   = hit_count_reg;
  assign bus.o_alloc_count = alloc_count_reg;

  // Training path; a flush in the same cycle drops the update.
  assign u_idx      = pc_index(bus.i_upd_pc);
  assign u_tag      = pc_tag(bus.i_upd_pc);
  assign u_entry    = entry_reg[u_idx];
  assign u_hit      = u_entry.valid && (u_entry.tag == u_tag);
  assign upd_fire   = bus.i_upd_en && !bus.i_flush;
  assign alloc_fire = upd_fire && !u_hit && bus.i_upd_taken;

  btb_sat_counter u_sat_counter (
    .ctr      (u_entry.ctr),
    .inc      (bus.i_upd_taken),
    .ctr_next (u_ctr_next)
  );

  always_comb begin
    for (int i = 0; i < BTB_ENTRIES; i++) begin
      entry_next[i] = entry_reg[i];
      if (bus.i_flush) begin
        entry_next[i].valid = 1'b0;
      end else if (upd_fire && (u_idx == BTB_INDEX_BITS'(i))) begin
        if (u_hit) begin
          entry_next[i].ctr = u_ctr_next;
          if (bus.i_upd_taken) entry_next[i].target = bus.i_upd_target;
        end else if (bus.i_upd_taken) begin
          entry_next[i].valid  = 1'b1;
          entry_next[i].tag    = u_tag;
          entry_next[i].target = bus.i_upd_target;
          entry_next[i].ctr    = CTR_ALLOC;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        entry_reg[i].valid  <= 1'b0;
        entry_reg[i].tag    <= '0;
        entry_reg[i].target <= '0;
        entry_reg[i].ctr    <= WNT;
      end
    end else begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        entry_reg[i] <= entry_next[i];
      end
    end
  end

  // Statistics saturate at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count_reg   <= '0;
      alloc_count_reg <= '0;
    end else begin
      if (predict_taken && (hit_count_reg != 16'hFFFF))
        hit_count_reg <= hit_count_reg + 16'd1;
      if (alloc_fire && (alloc_count_reg != 16'hFFFF))
        alloc_count_reg <= alloc_count_reg + 16'd1;
    end
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed plus randomized check of the branch target buffer against a
// small behavioural table model.
module tb_branch_target_buffer;

  logic clk = 1'b0;
  logic reset;

  branch_target_buffer_if bus ();

  branch_target_buffer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: one record per entry, plain integers.
  int m_valid  [16];
  int m_tag    [16];
  int m_target [16];
  int m_ctr    [16];
  int m_hits;
  int m_allocs;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  function automatic int idx_of(input int pc);
    return (pc / 2) % 16;
  endfunction

  function automatic int tag_of(input int pc);
    return pc / 32;
  endfunction

  function automatic int predicts(input int pc);
    int i;
    i = idx_of(pc);
    return (m_valid[i] != 0 && m_tag[i] == tag_of(pc) && m_ctr[i] >= 2) ? 1 : 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_target[i] = 0; m_ctr[i] = 1;
    end
    m_hits = 0;
    m_allocs = 0;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", nm, got, exp);
    end
  endtask

  // One cycle: drive inputs, check combinational and stats outputs against
  // the pre-edge model, then advance the model across the clock edge.
  task automatic step(input string nm, input int pc, input bit ue, input int upc,
                      input bit tk, input int tgt, input bit fl, input bit rs);
    int p, u;
    bus.i_pc         = 16'(pc);
    bus.i_upd_en     = ue;
    bus.i_upd_pc     = 16'(upc);
    bus.i_upd_taken  = tk;
    bus.i_upd_target = 16'(tgt);
    bus.i_flush      = fl;
    reset            = rs;
    #1;
    p = predicts(pc);
    chk({nm, "_valid"}, 32'(bus.o_valid), 32'(p));
    chk({nm, "_bt"},    32'(bus.o_BT),    (p != 0) ? 32'(m_target[idx_of(pc)]) : 32'd0);
    chk({nm, "_hits"},  32'(bus.o_hit_count),   32'(m_hits));
    chk({nm, "_alloc"}, 32'(bus.o_alloc_count), 32'(m_allocs));
    @(posedge clk);
    if (rs) begin
      model_reset();
    end else begin
      if (p != 0 && m_hits < 65535) m_hits++;
      if (fl) begin
        for (int i = 0; i < 16; i++) m_valid[i] = 0;
      end else if (ue) begin
        u = idx_of(upc);
        if (m_valid[u] != 0 && m_tag[u] == tag_of(upc)) begin
          if (tk) begin
            if (m_ctr[u] < 3) m_ctr[u]++;
            m_target[u] = tgt;
          end else if (m_ctr[u] > 0) begin
            m_ctr[u]--;
          end
        end else if (tk) begin
          m_valid[u] = 1; m_tag[u] = tag_of(upc); m_target[u] = tgt; m_ctr[u] = 2;
          if (m_allocs < 65535) m_allocs++;
        end
      end
    end
    @(negedge clk);
  endtask

  int rpc, rupc;

  initial begin
    bus.i_pc = '0; bus.i_upd_en = 0; bus.i_upd_pc = '0;
    bus.i_upd_taken = 0; bus.i_upd_target = '0; bus.i_flush = 0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();

    // Empty table after reset.
    step("reset_lookup", 'h0010, 0, 0, 0, 0, 0, 0);
    // Allocate; lookup in the write cycle sees the old contents.
    step("alloc_readold", 'h0010, 1, 'h0010, 1, 'h0040, 0, 0);
    step("alloc_hit", 'h0010, 0, 0, 0, 0, 0, 0);
    step("bit0_alias", 'h0011, 0, 0, 0, 0, 0, 0);
    // Counter walk down then saturate up.
    step("nt1", 'h0010, 1, 'h0010, 0, 0, 0, 0);
    step("nt2", 'h0010, 1, 'h0010, 0, 0, 0, 0);
    step("nt_floor", 'h0010, 1, 'h0010, 0, 0, 0, 0);
    step("tk1", 'h0010, 1, 'h0010, 1, 'h0040, 0, 0);
    step("tk2", 'h0010, 1, 'h0010, 1, 'h0044, 0, 0);
    step("tk3", 'h0010, 1, 'h0010, 1, 'h0048, 0, 0);
    step("tk4", 'h0010, 1, 'h0010, 1, 'h004C, 0, 0);
    // Saturated at 11: a single not-taken still predicts taken.
    step("sat_nt", 'h0010, 1, 'h0010, 0, 0, 0, 0);
    step("sat_check", 'h0010, 0, 0, 0, 0, 0, 0);
    // Same index, different tag replaces the entry.
    step("replace", 'h0010, 1, 'h0030, 1, 'h0100, 0, 0);
    step("old_tag", 'h0010, 0, 0, 0, 0, 0, 0);
    step("new_tag", 'h0030, 0, 0, 0, 0, 0, 0);
    // Not-taken miss never allocates.
    step("nt_miss", 'h0022, 1, 'h0022, 0, 'h0300, 0, 0);
    step("nt_miss_chk", 'h0022, 0, 0, 0, 0, 0, 0);
    // Flush beats a simultaneous taken update.
    step("flush", 'h0030, 1, 'h0044, 1, 'h0200, 1, 0);
    step("flush_old", 'h0030, 0, 0, 0, 0, 0, 0);
    step("flush_drop", 'h0044, 0, 0, 0, 0, 0, 0);
    step("realloc", 'h0030, 1, 'h0030, 1, 'h0120, 0, 0);
    step("realloc_chk", 'h0030, 0, 0, 0, 0, 0, 0);
    // Reset beats a simultaneous update.
    step("mid_reset", 'h0030, 1, 'h0050, 1, 'h0500, 0, 1);
    step("post_reset", 'h0050, 0, 0, 0, 0, 0, 0);
    step("post_reset2", 'h0030, 0, 0, 0, 0, 0, 0);

    // Random traffic over a small PC space so hits and conflicts are common.
    for (int n = 0; n < 400; n++) begin
      rpc  = int'(($urandom_range(0, 3) << 5) | ($urandom_range(0, 15) << 1) | $urandom_range(0, 1));
      rupc = int'(($urandom_range(0, 3) << 5) | ($urandom_range(0, 15) << 1) | $urandom_range(0, 1));
      step("rand", rpc, $urandom_range(0, 3) != 0, rupc, $urandom_range(0, 2) != 0,
           int'($urandom_range(0, 65535)), $urandom_range(0, 39) == 0,
           $urandom_range(0, 149) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
